lru_set_replacer: RTL and testbench

Parametrised true-LRU replacement unit for the L1 cache controller. It holds one age vector per cache set for a configurable associativity, and applies two kinds of update: touch (a way becomes MRU) and invalidate (a way becomes LRU). It answers victim queries with a registered way index, preferring an invalid way over the LRU way. It replaces the single-set 4-way LRU block and sits between the tag-compare stage and the line-fill/eviction logic.

---
 rtl/lru_set_replacer.sv | 129 ++++++++++++
 tb/tb_lru_set_replacer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lru_set_replacer.sv
// True-LRU replacement state for every set of a WAYS-way cache, with touch/invalidate
// updates and a registered victim query that prefers invalid ways over the LRU way.
module lru_set_replacer #(
  parameter int WAYS = 8,
  parameter int SETS = 64,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             access_valid,
  input  logic             access_inv,
  input  logic [SET_W-1:0] access_set,
  input  logic [WAY_W-1:0] access_way,
  input  logic             query_valid,
  input  logic [SET_W-1:0] query_set,
  input  logic [WAYS-1:0]  query_valid_mask,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_from_invalid
);

  localparam logic [WAY_W-1:0] AGE_MRU = '0;
  localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);

  // Flattened view of every age register, indexed [set][way].
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] ages;

  logic [WAYS-1:0][WAY_W-1:0] access_ages;
  logic [WAY_W-1:0]           access_age;
  logic [WAYS-1:0][WAY_W-1:0] query_ages;

  assign access_ages = ages[access_set];
  assign access_age  = access_ages[access_way];
  assign query_ages  = ages[query_set];

  // Each way compares its own age against the addressed way's age, so a set
  // updates in one cycle and stays a permutation of 0..WAYS-1.
  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : gen_set
      logic set_hit;
      assign set_hit = access_valid && (access_set == SET_W'(gi));

      for (genvar wi = 0; wi < WAYS; wi++) begin : gen_way
        logic [WAY_W-1:0] age_reg;
        logic [WAY_W-1:0] age_next;
        logic             way_hit;

        assign way_hit = (access_way == WAY_W'(wi));

        always_comb begin
          age_next = age_reg;
          if (way_hit) begin
            age_next = access_inv ? AGE_LRU : AGE_MRU;
          end else if (!access_inv && (age_reg < access_age)) begin
            age_next = age_reg + WAY_W'(1);
          end else if (access_inv && (age_reg > access_age)) begin
            age_next = age_reg - WAY_W'(1);
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            age_reg <= WAY_W'(wi);
          end else if (set_hit) begin
            age_reg <= age_next;
          end
        end

        assign ages[gi][wi] = age_reg;
      end
    end
  endgenerate

  logic [WAYS-1:0]  is_lru;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim_way_next;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : gen_lru_flag
      assign is_lru[gi] = (query_ages[gi] == AGE_LRU);
    end
  endgenerate

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!query_valid_mask[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (is_lru[w]) begin
        lru_way = WAY_W'(w);
      end
    end
  end

  assign victim_way_next = inv_found ? inv_way : lru_way;

  logic             victim_valid_reg;
  logic [WAY_W-1:0] victim_way_reg;
  logic             victim_from_invalid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_valid_reg        <= 1'b0;
      victim_way_reg          <= '0;
      victim_from_invalid_reg <= 1'b0;
    end else begin
      victim_valid_reg <= query_valid;
      if (query_valid) begin
        victim_way_reg          <= victim_way_next;
        victim_from_invalid_reg <= inv_found;
      end
    end
  end

  assign victim_valid        = victim_valid_reg;
  assign victim_way          = victim_way_reg;
  assign victim_from_invalid = victim_from_invalid_reg;

endmodule

// File: tb/tb_lru_set_replacer.sv
// Bench for lru_set_replacer: directed scenarios then a random update/query stream,
// checked against a per-set recency list (front = MRU, back = LRU).
module tb_lru_set_replacer;

  localparam int WAYS = 8;
  localparam int SETS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       access_valid = 1'b0;
  logic       access_inv = 1'b0;
  logic [5:0] access_set = '0;
  logic [2:0] access_way = '0;
  logic       query_valid = 1'b0;
  logic [5:0] query_set = '0;
  logic [7:0] query_valid_mask = 8'hFF;
  logic       victim_valid;
  logic [2:0] victim_way;
  logic       victim_from_invalid;

  int tests = 0;
  int fails = 0;

  // Recency order per set: element 0 is MRU, last element is LRU.
  int ord [SETS][$];

  lru_set_replacer #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk),
    .rst(rst),
    .access_valid(access_valid),
    .access_inv(access_inv),
    .access_set(access_set),
    .access_way(access_way),
    .query_valid(query_valid),
    .query_set(query_set),
    .query_valid_mask(query_valid_mask),
    .victim_valid(victim_valid),
    .victim_way(victim_way),
    .victim_from_invalid(victim_from_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      ord[s].delete();
      for (int w = 0; w < WAYS; w++) ord[s].push_back(w);
    end
  endtask

  task automatic model_update(input bit inv, input int s, input int w);
    for (int i = 0; i < ord[s].size(); i++) begin
      if (ord[s][i] == w) begin
        ord[s].delete(i);
        break;
      end
    end
    if (inv) ord[s].push_back(w);
    else     ord[s].push_front(w);
  endtask

  // One clock: drive update/query, advance past the edge, then check the result.
  task automatic do_cycle(input bit av, input bit inv, input int aset, input int away,
                          input bit qv, input int qset, input logic [7:0] qmask,
                          input string tag);
    int exp_w;
    bit exp_fi;
    exp_w  = 0;
    exp_fi = 1'b0;
    access_valid     = av;
    access_inv       = inv;
    access_set       = 6'(aset);
    access_way       = 3'(away);
    query_valid      = qv;
    query_set        = 6'(qset);
    query_valid_mask = qmask;
    if (qv) begin
      if (qmask != 8'hFF) begin
        exp_fi = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (!qmask[w]) begin
            exp_w = w;
            break;
          end
        end
      end else begin
        exp_w = ord[qset][WAYS-1];
      end
    end
    @(posedge clk);
    #1;
    if (av) model_update(inv, aset, away);
    access_valid = 1'b0;
    query_valid  = 1'b0;
    check({tag, "/valid"}, 32'(victim_valid), 32'(qv));
    if (qv) begin
      check({tag, "/way"}, 32'(victim_way), 32'(exp_w));
      check({tag, "/from_inv"}, 32'(victim_from_invalid), 32'(exp_fi));
      if (ord[qset].size() != WAYS) begin
        tests++;
        fails++;
        $error("FAIL %s/model_size: observed %0d expected %0d", tag, ord[qset].size(), WAYS);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset/valid", 32'(victim_valid), 32'd0);
    check("reset/way", 32'(victim_way), 32'd0);
    check("reset/from_inv", 32'(victim_from_invalid), 32'd0);
    rst = 1'b0;

    do_cycle(0, 0, 0, 0, 1, 0, 8'hFF, "reset_query");
    do_cycle(0, 0, 0, 0, 0, 0, 8'hFF, "idle");

    for (int w = 7; w >= 1; w--) do_cycle(1, 0, 3, w, 0, 0, 8'hFF, "touch_set3");
    do_cycle(0, 0, 0, 0, 1, 3, 8'hFF, "set3_lru0");
    check("set3_lru0/literal", 32'(victim_way), 32'd0);
    do_cycle(0, 0, 0, 0, 1, 5, 8'hFF, "set5_untouched");
    check("set5_untouched/literal", 32'(victim_way), 32'd7);

    do_cycle(1, 1, 1, 2, 0, 0, 8'hFF, "inv_set1_way2");
    do_cycle(0, 0, 0, 0, 1, 1, 8'hFF, "set1_after_inv");
    check("set1_after_inv/literal", 32'(victim_way), 32'd2);
    do_cycle(1, 0, 1, 2, 0, 0, 8'hFF, "touch_set1_way2");
    do_cycle(0, 0, 0, 0, 1, 1, 8'hFF, "set1_after_touch");

    do_cycle(0, 0, 0, 0, 1, 3, 8'b1110_1011, "mask_invalid");
    check("mask_invalid/literal", 32'(victim_way), 32'd2);

    do_cycle(1, 0, 4, 7, 1, 4, 8'hFF, "same_cycle_pre");
    check("same_cycle_pre/literal", 32'(victim_way), 32'd7);
    do_cycle(0, 0, 0, 0, 1, 4, 8'hFF, "same_cycle_post");
    check("same_cycle_post/literal", 32'(victim_way), 32'd6);

    do_cycle(0, 0, 0, 0, 1, 3, 8'hFF, "pre_reset_query");
    rst = 1'b1;
    #1;
    check("async_reset/valid", 32'(victim_valid), 32'd0);
    check("async_reset/way", 32'(victim_way), 32'd0);
    access_valid = 1'b1;
    access_inv   = 1'b0;
    access_set   = 6'd0;
    access_way   = 3'd7;
    @(posedge clk);
    #1;
    access_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    do_cycle(0, 0, 0, 0, 1, 0, 8'hFF, "post_reset_set0");
    check("post_reset_set0/literal", 32'(victim_way), 32'd7);
    do_cycle(0, 0, 0, 0, 1, 3, 8'hFF, "post_reset_set3");

    for (int n = 0; n < 3000; n++) begin
      bit av, inv, qv;
      int aset, away, qset;
      logic [7:0] m;
      av   = ($urandom_range(0, 3) != 0);
      inv  = ($urandom_range(0, 3) == 0);
      qv   = ($urandom_range(0, 3) != 0);
      aset = (n % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, SETS - 1);
      away = $urandom_range(0, WAYS - 1);
      qset = ($urandom_range(0, 2) == 0) ? aset : ((n % 4 == 0) ? $urandom_range(0, 3)
                                                                : $urandom_range(0, SETS - 1));
      m    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      do_cycle(av, inv, aset, away, qv, qset, m, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
